sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter WAIT_CYCLES, default 1, number of extra SRAM access cycles held in ACCESS (legal 0..7).
REQ-002 clk  input  1  system clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous active-low reset (rst==0 resets immediately).
REQ-004 if_req_i  input  1  instruction-fetch read request, level, held until if_ready_o.
REQ-005 if_addr_i  input  16  fetch word address.
REQ-006 if_data_o  output  16  fetched instruction, valid while if_ready_o=1.
REQ-007 if_ready_o  output  1  one-cycle completion pulse for fetch.
REQ-008 mem_req_i  input  1  data-stage request, level, held until mem_ready_o.
REQ-009 mem_we_i  input  1  1=write, 0=read; sampled at grant.
REQ-010 mem_addr_i  input  16  data word address.
REQ-011 mem_wdata_i  input  16  write data.
REQ-012 mem_rdata_o  output  16  read data, valid while mem_ready_o=1.
REQ-013 mem_ready_o  output  1  one-cycle completion pulse for data stage.
REQ-014 stall_req_o  output  1  pipeline stall request to the stall controller.
REQ-015 sram_addr_o  output  16  SRAM address.
REQ-016 sram_data_o / sram_data_i / sram_data_oe_o  output 16 / input 16 / output 1  split tristate data bus; oe=1 drives bus.
REQ-017 sram_ce_n_o, sram_oe_n_o, sram_we_n_o  output  1 each  active-low SRAM strobes.

Function
REQ-018 FSM states IDLE, SETUP, ACCESS, DONE.
REQ-019 IDLE: if mem_req_i=1 grant MEM, else if if_req_i=1 grant IF, else stay; on grant latch address, direction (IF always read), write data; go SETUP.
REQ-020 SETUP: one cycle; ce_n=0, address driven; read: oe_n=0; write: data_oe=1, we_n=1.
REQ-021 ACCESS: exactly WAIT_CYCLES+1 cycles counted by a 3-bit down-counter; write: we_n=0, data_oe=1; read: oe_n=0.
REQ-022 Read data captured from sram_data_i on the last ACCESS clock edge into a 16-bit holding register.
REQ-023 DONE: one cycle; ready pulse to granted port only; we_n=1; write keeps data_oe=1 for hold time; read data presented from holding register.
REQ-024 Latency: request sampled in IDLE at cycle 0 -> ready at cycle WAIT_CYCLES+3.
REQ-025 DONE arbitration excludes the port just served: if the other port requests, grant it and go SETUP directly; else IDLE.
REQ-026 No preemption: a request arriving during another access waits; MEM priority applies only at arbitration points.
REQ-027 stall_req_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o), combinational.
REQ-028 Request dropped mid-access: access still completes; ready pulse still issued and ignored.
REQ-029 Outside SETUP/ACCESS/DONE: ce_n=oe_n=we_n=1, data_oe=0.
REQ-030 if_data_o/mem_rdata_o read 0x0000 when their ready is 0.

Reset
REQ-031 On rst=0: state IDLE, counter 0, holding register 0x0000, all ready 0, strobes 1, data_oe 0, sram_addr_o 0x0000, sram_data_o 0x0000.
REQ-032 Reset mid-access aborts immediately; SRAM bus released in the same cycle; no ready pulse after reset release.

Structure
REQ-033 State encodings, ZeroWord, WriteEnable/ReadEnable and strobe-level constants live in the shared defines file.
REQ-034 Single module; no sub-module (counter and FSM are inline).

Verification
REQ-035 WAIT_CYCLES=1, IF read 0x0010 with SRAM model holding 0x6A05 -> if_ready_o pulses at cycle 4, if_data_o=0x6A05, stall_req_o high cycles 0-3.
REQ-036 MEM write 0x1234 to 0x8000 -> we_n low exactly 2 cycles, data_oe high SETUP through DONE; readback of 0x8000 returns 0x1234.
REQ-037 if_req_i and mem_req_i raised same cycle -> MEM served first, IF granted from DONE with no IDLE cycle, IF ready at cycle 8.
REQ-038 Both held continuously for 4 transactions -> grants alternate MEM, IF, MEM, IF; neither starves.
REQ-039 rst pulled low during ACCESS of a write -> we_n, ce_n go 1 and data_oe 0 asynchronously; after release FSM in IDLE, no ready pulse.
REQ-040 WAIT_CYCLES=0 read -> ready at cycle 3; WAIT_CYCLES=7 read -> ready at cycle 10.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// rtl/sram_arbiter_pkg.sv - shared encodings and constants for the SRAM arbiter
package sram_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    typedef enum logic {
        PORT_IF  = 1'b0,
        PORT_MEM = 1'b1
    } port_t;

    localparam logic [15:0] ZERO_WORD     = 16'h0000;
    localparam logic        WRITE_ENABLE  = 1'b1;
    localparam logic        READ_ENABLE   = 1'b0;
    localparam logic        STROBE_ACTIVE = 1'b0;
    localparam logic        STROBE_IDLE   = 1'b1;

endpackage

// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - two-port (fetch / data) arbiter for an asynchronous SRAM
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_i,
    input  logic [15:0] if_addr_i,
    output logic [15:0] if_data_o,
    output logic        if_ready_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [15:0] mem_addr_i,
    input  logic [15:0] mem_wdata_i,
    output logic [15:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        stall_req_o,
    output logic [15:0] sram_addr_o,
    output logic [15:0] sram_data_o,
    input  logic [15:0] sram_data_i,
    output logic        sram_data_oe_o,
    output logic        sram_ce_n_o,
    output logic        sram_oe_n_o,
    output logic        sram_we_n_o
);

    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES);

    state_t      state_q, state_d;
    port_t       port_q, port_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] hold_q;
    logic [2:0]  cnt_q;
    logic        grant;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            port_q  <= PORT_IF;
            we_q    <= READ_ENABLE;
            addr_q  <= ZERO_WORD;
            wdata_q <= ZERO_WORD;
            hold_q  <= ZERO_WORD;
            cnt_q   <= 3'd0;
        end else begin
            state_q <= state_d;
            port_q  <= port_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            if (state_q == ST_SETUP)
                cnt_q <= WAIT_LOAD;
            else if (state_q == ST_ACCESS && cnt_q != 3'd0)
                cnt_q <= cnt_q - 3'd1;
            // Sample on the final access edge while OE is still asserted
            if (state_q == ST_ACCESS && cnt_q == 3'd0 && we_q == READ_ENABLE)
                hold_q <= sram_data_i;
        end
    end

    always_comb begin
        state_d = state_q;
        port_d  = port_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        grant   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_i) begin
                    grant  = 1'b1;
                    port_d = PORT_MEM;
                end else if (if_req_i) begin
                    grant  = 1'b1;
                    port_d = PORT_IF;
                end
            end
            ST_SETUP:  state_d = ST_ACCESS;
            ST_ACCESS: if (cnt_q == 3'd0) state_d = ST_DONE;
            ST_DONE: begin
                // The port just served is excluded so a waiting peer cannot starve
                state_d = ST_IDLE;
                if (port_q == PORT_IF && mem_req_i) begin
                    grant  = 1'b1;
                    port_d = PORT_MEM;
                end else if (port_q == PORT_MEM && if_req_i) begin
                    grant  = 1'b1;
                    port_d = PORT_IF;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (grant) begin
            state_d = ST_SETUP;
            if (port_d == PORT_MEM) begin
                we_d    = mem_we_i;
                addr_d  = mem_addr_i;
                wdata_d = mem_wdata_i;
            end else begin
                we_d    = READ_ENABLE;
                addr_d  = if_addr_i;
                wdata_d = ZERO_WORD;
            end
        end
    end

    always_comb begin
        sram_ce_n_o    = STROBE_IDLE;
        sram_oe_n_o    = STROBE_IDLE;
        sram_we_n_o    = STROBE_IDLE;
        sram_data_oe_o = 1'b0;
        case (state_q)
            ST_SETUP, ST_ACCESS: begin
                sram_ce_n_o = STROBE_ACTIVE;
                if (we_q == WRITE_ENABLE) begin
                    sram_data_oe_o = 1'b1;
                    if (state_q == ST_ACCESS) sram_we_n_o = STROBE_ACTIVE;
                end else begin
                    sram_oe_n_o = STROBE_ACTIVE;
                end
            end
            ST_DONE: begin
                sram_ce_n_o    = STROBE_ACTIVE;
                sram_data_oe_o = (we_q == WRITE_ENABLE);
            end
            default: ;
        endcase
    end

    assign sram_addr_o = addr_q;
    assign sram_data_o = wdata_q;
    assign if_ready_o  = (state_q == ST_DONE) && (port_q == PORT_IF);
    assign mem_ready_o = (state_q == ST_DONE) && (port_q == PORT_MEM);
    assign if_data_o   = if_ready_o  ? hold_q : ZERO_WORD;
    assign mem_rdata_o = mem_ready_o ? hold_q : ZERO_WORD;
    assign stall_req_o = (if_req_i & ~if_ready_o) | (mem_req_i & ~mem_ready_o);

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - self-checking bench for sram_arbiter with SRAM and reference models
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [15:0] if_addr, mem_addr, mem_wdata;
    logic [15:0] if_data, mem_rdata;
    logic        if_ready, mem_ready, stall;
    logic [15:0] sram_addr, sram_dout, sram_din;
    logic        sram_doe, ce_n, oe_n, we_n;

    int checks = 0;
    int errors = 0;

    logic [15:0] sram [0:65535];
    logic [15:0] ref_mem [logic [15:0]];

    always #5 clk = ~clk;

    sram_arbiter #(.WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst(rst),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_data_o(if_data), .if_ready_o(if_ready),
        .mem_req_i(mem_req), .mem_we_i(mem_we), .mem_addr_i(mem_addr), .mem_wdata_i(mem_wdata),
        .mem_rdata_o(mem_rdata), .mem_ready_o(mem_ready), .stall_req_o(stall),
        .sram_addr_o(sram_addr), .sram_data_o(sram_dout), .sram_data_i(sram_din),
        .sram_data_oe_o(sram_doe), .sram_ce_n_o(ce_n), .sram_oe_n_o(oe_n), .sram_we_n_o(we_n)
    );

    assign sram_din = (!ce_n && !oe_n) ? sram[sram_addr] : 16'h0000;

    always @(posedge clk)
        if (!ce_n && !we_n && sram_doe) sram[sram_addr] <= sram_dout;

    // Two extra instances: index 0 with WAIT_CYCLES=0, index 1 with WAIT_CYCLES=7
    logic        x_if_req [2];
    logic        x_mem_req [2];
    logic [15:0] x_if_addr [2];
    logic [15:0] x_mem_addr [2];
    logic [15:0] x_if_data [2];
    logic [15:0] x_mem_rdata [2];
    logic        x_if_ready [2];
    logic        x_mem_ready [2];
    logic        x_stall [2];
    logic [15:0] x_addr [2];
    logic [15:0] x_dout [2];
    logic [15:0] x_din [2];
    logic        x_doe [2];
    logic        x_ce_n [2];
    logic        x_oe_n [2];
    logic        x_we_n [2];

    for (genvar k = 0; k < 2; k++) begin : g_x
        sram_arbiter #(.WAIT_CYCLES(k == 0 ? 0 : 7)) u_x (
            .clk(clk), .rst(rst),
            .if_req_i(x_if_req[k]), .if_addr_i(x_if_addr[k]), .if_data_o(x_if_data[k]),
            .if_ready_o(x_if_ready[k]),
            .mem_req_i(x_mem_req[k]), .mem_we_i(1'b0), .mem_addr_i(x_mem_addr[k]),
            .mem_wdata_i(16'h0000), .mem_rdata_o(x_mem_rdata[k]), .mem_ready_o(x_mem_ready[k]),
            .stall_req_o(x_stall[k]), .sram_addr_o(x_addr[k]), .sram_data_o(x_dout[k]),
            .sram_data_i(x_din[k]), .sram_data_oe_o(x_doe[k]), .sram_ce_n_o(x_ce_n[k]),
            .sram_oe_n_o(x_oe_n[k]), .sram_we_n_o(x_we_n[k])
        );
        assign x_din[k] = (x_oe_n[k] == 1'b0) ? (x_addr[k] ^ 16'hA5C3) : 16'h0000;
    end

    function automatic logic [15:0] init_word(input logic [15:0] a);
        return {a[7:0], ~a[7:0]} ^ 16'h5A00;
    endfunction

    function automatic logic [15:0] ref_read(input logic [15:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return init_word(a);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One transaction on the WAIT_CYCLES=1 instance; starts just after a rising edge in IDLE
    task automatic do_access(input bit is_mem, input bit we, input logic [15:0] addr,
                             input logic [15:0] wd, output logic [15:0] rd, output int lat,
                             output int we_low, output int oe_cyc, output bit side_ok);
        side_ok = 1'b1; lat = -1; we_low = 0; oe_cyc = 0; rd = 16'h0000;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wd;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!we_n) we_low++;
            if (sram_doe) oe_cyc++;
            if (is_mem ? mem_ready : if_ready) begin
                lat = c;
                rd = is_mem ? mem_rdata : if_data;
                if (stall) side_ok = 1'b0;
                break;
            end
            if (!stall || if_data !== 16'h0000 || mem_rdata !== 16'h0000) side_ok = 1'b0;
        end
        mem_req = 1'b0; if_req = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic x_read(input int k, input bit is_mem, input logic [15:0] addr,
                          output int lat, output logic [15:0] rd);
        lat = -1; rd = 16'h0000;
        if (is_mem) begin x_mem_req[k] = 1'b1; x_mem_addr[k] = addr; end
        else begin x_if_req[k] = 1'b1; x_if_addr[k] = addr; end
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (is_mem ? x_mem_ready[k] : x_if_ready[k]) begin
                lat = c;
                rd = is_mem ? x_mem_rdata[k] : x_if_data[k];
                break;
            end
        end
        x_mem_req[k] = 1'b0; x_if_req[k] = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [15:0] rd, a, d, mem_d, if_d;
        int lat, wl, oc, mem_t, if_t, n, kind;
        bit ok, quiet;
        bit seq_port [4];
        int seq_t [4];
        logic [15:0] seq_d [4];

        for (int i = 0; i < 65536; i++) sram[i] = init_word(16'(i));
        sram[16'h0010] = 16'h6A05;
        ref_mem[16'h0010] = 16'h6A05;

        rst = 1'b0; if_req = 0; mem_req = 0; mem_we = 0;
        if_addr = 0; mem_addr = 0; mem_wdata = 0;
        for (int k = 0; k < 2; k++) begin
            x_if_req[k] = 0; x_mem_req[k] = 0; x_if_addr[k] = 0; x_mem_addr[k] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_strobes", {ce_n, oe_n, we_n, sram_doe}, 4'b1110);
        check("rst_addr", sram_addr, 16'h0000);
        check("rst_dout", sram_dout, 16'h0000);
        check("rst_ready", {if_ready, mem_ready, stall}, 3'b000);
        rst = 1'b1;
        @(posedge clk); #1;

        // Fetch of a known word
        do_access(1'b0, 1'b0, 16'h0010, 16'h0, rd, lat, wl, oc, ok);
        check("if_latency", lat, 4);
        check("if_data", rd, 16'h6A05);
        check("if_stall_and_zero", ok, 1);

        // Write then readback
        do_access(1'b1, 1'b1, 16'h8000, 16'h1234, rd, lat, wl, oc, ok);
        ref_mem[16'h8000] = 16'h1234;
        check("wr_latency", lat, 4);
        check("wr_we_low_cycles", wl, 2);
        check("wr_data_oe_cycles", oc, 4);
        do_access(1'b1, 1'b0, 16'h8000, 16'h0, rd, lat, wl, oc, ok);
        check("rd_back", rd, ref_read(16'h8000));
        check("rd_no_we_no_oe", {wl[7:0], oc[7:0]}, 16'h0000);

        // Simultaneous requests: data port wins, fetch follows straight from DONE
        mem_t = -1; if_t = -1; mem_d = 0; if_d = 0;
        mem_req = 1; mem_we = 0; mem_addr = 16'h0020; if_req = 1; if_addr = 16'h0030;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (mem_ready && mem_t < 0) begin mem_t = c; mem_d = mem_rdata; mem_req = 0; end
            if (if_ready && if_t < 0) begin if_t = c; if_d = if_data; if_req = 0; end
            if (mem_t >= 0 && if_t >= 0) break;
        end
        mem_req = 0; if_req = 0;
        @(posedge clk); #1;
        check("both_mem_t", mem_t, 4);
        check("both_if_t", if_t, 8);
        check("both_mem_d", mem_d, ref_read(16'h0020));
        check("both_if_d", if_d, ref_read(16'h0030));

        // Both held continuously: service alternates
        n = 0;
        mem_req = 1; mem_we = 0; mem_addr = 16'h0040; if_req = 1; if_addr = 16'h0050;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (mem_ready || if_ready) begin
                seq_port[n] = mem_ready; seq_t[n] = c;
                seq_d[n] = mem_ready ? mem_rdata : if_data;
                n++;
                if (n == 4) begin mem_req = 0; if_req = 0; end
            end
        end
        mem_req = 0; if_req = 0;
        @(posedge clk); #1;
        check("alt_count", n, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("alt_port%0d", i), seq_port[i], (i % 2 == 0));
            check($sformatf("alt_time%0d", i), seq_t[i], 4 * (i + 1));
            check($sformatf("alt_data%0d", i), seq_d[i],
                  ref_read(i % 2 == 0 ? 16'h0040 : 16'h0050));
        end

        // Randomised single transactions against the reference memory
        for (int i = 0; i < 30; i++) begin
            kind = $urandom_range(0, 2);
            a = 16'($urandom_range(0, 255));
            d = 16'($urandom);
            do_access(kind != 0, kind == 2, a, d, rd, lat, wl, oc, ok);
            check($sformatf("rnd%0d_lat", i), lat, 4);
            if (kind == 2) begin
                ref_mem[a] = d;
                check($sformatf("rnd%0d_we", i), wl, 2);
            end else begin
                check($sformatf("rnd%0d_data", i), rd, ref_read(a));
            end
        end

        // Reset during the access phase of a write
        mem_req = 1; mem_we = 1; mem_addr = 16'h9000; mem_wdata = 16'hBEEF;
        repeat (3) @(negedge clk);
        check("rst_pre_we_low", we_n, 1'b0);
        #2 rst = 1'b0;
        #1;
        check("rst_async_strobes", {ce_n, we_n, sram_doe}, 3'b110);
        check("rst_async_bus", {sram_addr, sram_dout}, 32'h0);
        mem_req = 0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (mem_ready || if_ready || !ce_n) quiet = 1'b0;
        end
        check("rst_release_quiet", quiet, 1);
        @(posedge clk); #1;

        // Latency at the extremes of the wait setting
        x_read(0, 1'b0, 16'h1357, lat, rd);
        check("w0_if_lat", lat, 3);
        check("w0_if_data", rd, 16'h1357 ^ 16'hA5C3);
        x_read(0, 1'b1, 16'h2468, lat, rd);
        check("w0_mem_lat", lat, 3);
        check("w0_mem_data", rd, 16'h2468 ^ 16'hA5C3);
        x_read(1, 1'b0, 16'hFFFF, lat, rd);
        check("w7_if_lat", lat, 10);
        check("w7_if_data", rd, 16'hFFFF ^ 16'hA5C3);
        x_read(1, 1'b1, 16'h0001, lat, rd);
        check("w7_mem_lat", lat, 10);
        check("w7_mem_data", rd, 16'h0001 ^ 16'hA5C3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
